// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  // Fetch stage side: issues requests, receives the instruction word.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  // Memory side: observes requests, returns data and acknowledge.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction fetch stage: owns the PC, fetches one word per instruction
// over a req/ack handshake, holds it for decode/execute, and selects the next
// PC (sequential, branch or jump) when the datapath commits.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        imem,
  input  logic                 commit,
  input  logic [1:0]           branch,
  input  logic                 jump,
  input  logic                 zero,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic                 instr_valid,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          retired,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned XLEN   = 32;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   ir, ir_d;
  logic [XLEN-1:0]   pc_d, pc4_d;
  logic [XLEN-1:0]   retired_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic [1:0]        code_d;
  logic              req_q;

  logic [XLEN-1:0]   br_off;
  logic              br_taken;
  logic [XLEN-1:0]   next_pc;

  // Next PC selection for the held instruction: jump over branch over sequential.
  always_comb begin
    br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
    br_taken = ((branch == 2'b01) && zero) || ((branch == 2'b10) && !zero);
    next_pc  = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    end else if (br_taken) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // Next-state and next-register-value logic.
  always_comb begin
    state_d   = state;
    ir_d      = ir;
    pc_d      = pc;
    pc4_d     = pc_plus4;
    retired_d = retired;
    wait_d    = wait_cnt;
    code_d    = fault_code;

    case (state)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end

      S_FETCH: begin
        // An ack on the expiry cycle still completes the fetch.
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = S_HOLD;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = S_FAULT;
          code_d  = CODE_TIMEOUT;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end

      S_HOLD: begin
        if (commit) begin
          // PC and retired count update even when the target is misaligned,
          // so the faulting target stays visible for debug.
          pc_d      = next_pc;
          pc4_d     = next_pc + XLEN'(4);
          retired_d = retired + XLEN'(1);
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
            code_d  = CODE_MISALIGN;
          end else begin
            state_d = S_FETCH;
            wait_d  = '0;
          end
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; status outputs are registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ir          <= '0;
      pc          <= RESET_PC;
      pc_plus4    <= RESET_PC + XLEN'(4);
      retired     <= '0;
      wait_cnt    <= '0;
      fault_code  <= CODE_NONE;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      ir          <= ir_d;
      pc          <= pc_d;
      pc_plus4    <= pc4_d;
      retired     <= retired_d;
      wait_cnt    <= wait_d;
      fault_code  <= code_d;
      req_q       <= (state_d == S_FETCH);
      instr_valid <= (state_d == S_HOLD);
      fault       <= (state_d == S_FAULT);
    end
  end

  // Bus and decode fields are taken straight from registers.
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;
  assign instr          = ir;
  assign opcode         = ir[31:26];
  assign funct          = ir[5:0];

endmodule
